// File: rtl/gated_mux_pipe.sv
// gated_mux_pipe: per-lane zero-gate mux behind a 2-entry skid buffer; GATED_MUX_ZERO_CNT_EN adds a saturating zero_cnt output.
module gated_mux_pipe #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0]       s,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHANNELS-1:0] out,
  output logic                      out_zero
`ifdef GATED_MUX_ZERO_CNT_EN
  ,
  output logic [15:0]               zero_cnt
`endif
);
  localparam int N = WIDTH * CHANNELS;
  logic [N-1:0] gated, main_d, main_q, skid_d, skid_q;
  logic main_v_d, main_v_q, skid_v_d, skid_v_q, main_z_d, main_z_q, skid_z_d, skid_z_q;
  logic acc, xfer, gated_z, load_main, load_skid, shift;
  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_lane
      assign gated[i*WIDTH +: WIDTH] = s[i] ? in[i*WIDTH +: WIDTH] : '0;
    end
  endgenerate
  always_comb begin
    acc       = in_valid && !skid_v_q;
    xfer      = main_v_q && out_ready;
    gated_z   = ~|gated;
    load_main = acc && (!main_v_q || xfer);
    load_skid = acc && main_v_q && !xfer;
    shift     = xfer && skid_v_q;
    main_v_d  = !flush && (acc || skid_v_q || (main_v_q && !xfer));
    skid_v_d  = !flush && (load_skid || (skid_v_q && !xfer));
    main_d    = shift ? skid_q : load_main ? gated : main_q;
    main_z_d  = shift ? skid_z_q : load_main ? gated_z : main_z_q;
    skid_d    = load_skid ? gated : skid_q;
    skid_z_d  = load_skid ? gated_z : skid_z_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      main_z_q <= 1'b0;
      skid_z_q <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_z_q <= main_z_d;
      skid_z_q <= skid_z_d;
    end
  end
  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out       = main_q;
  assign out_zero  = main_z_q;
`ifdef GATED_MUX_ZERO_CNT_EN
  logic [15:0] zero_cnt_d, zero_cnt_q;
  always_comb zero_cnt_d = flush ? 16'd0 : (xfer && main_z_q && zero_cnt_q != 16'hFFFF) ? zero_cnt_q + 16'd1 : zero_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_cnt_q <= 16'd0;
    else zero_cnt_q <= zero_cnt_d;
  end
  assign zero_cnt = zero_cnt_q;
`endif
endmodule

// File: tb/tb_gated_mux_pipe.sv
// tb_gated_mux_pipe: randomized bench against a queue-based FIFO model of the gated mux pipe.
module tb_gated_mux_pipe;
  localparam int W = 12, C = 4, N = W * C;
  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [N-1:0] in = '0;
  logic [C-1:0] s = '0;
  logic out_valid, in_ready, out_zero;
  logic [N-1:0] out;
`ifdef GATED_MUX_ZERO_CNT_EN
  logic [15:0] zero_cnt;
`endif
  int checks = 0, errors = 0;
  logic [N:0] q[$];
  int cnt = 0;
  logic [N-1:0] a, b, c;
  always #5 clk = ~clk;
  gated_mux_pipe #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .s(s), .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_zero(out_zero)
`ifdef GATED_MUX_ZERO_CNT_EN
    , .zero_cnt(zero_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [N:0] gate(input logic [N-1:0] d, input logic [C-1:0] sel);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < C; k++) if (sel[k]) r[k*W +: W] = d[k*W +: W];
    return {r == '0, r};
  endfunction
  function automatic logic [N-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[N-1:0];
  endfunction
  task automatic model_check();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out", 64'(out), 64'(q[0][N-1:0]));
      chk("out_zero", 64'(out_zero), 64'(q[0][N]));
    end
`ifdef GATED_MUX_ZERO_CNT_EN
    chk("zero_cnt", 64'(zero_cnt), 64'(cnt));
`endif
  endtask
  task automatic cyc(input logic v, input logic [N-1:0] d, input logic [C-1:0] sel, input logic ordy, input logic fl);
    logic xf, ac;
    @(negedge clk);
    model_check();
    in_valid = v; in = d; s = sel; out_ready = ordy; flush = fl;
    #1 chk("in_ready_hold", 64'(in_ready), 64'(q.size() < 2));
    @(posedge clk);
    xf = q.size() > 0 && ordy;
    ac = v && q.size() < 2;
    if (fl) begin
      q.delete();
      cnt = 0;
    end else begin
      if (xf) begin
        if (q[0][N] && cnt < 65535) cnt++;
        void'(q.pop_front());
      end
      if (ac) q.push_back(gate(d, sel));
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0; in_valid = 0; flush = 0;
    q.delete();
    cnt = 0;
    #1 chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_out", 64'(out), 0);
    chk("rst_zero", 64'(out_zero), 0);
    @(negedge clk);
    chk("rst_hold_valid", 64'(out_valid), 0);
    rst_n = 1;
  endtask
  initial begin
    do_reset();
    cyc(0, '0, '0, 1, 0);
    cyc(1, 48'h001FFF123ABC, 4'b0101, 1, 0);
    #1 chk("beat_out", 64'(out), 64'h000FFF000ABC);
    chk("beat_zero", 64'(out_zero), 0);
    chk("beat_valid", 64'(out_valid), 1);
    cyc(0, '0, '0, 1, 0);
    #1 chk("beat_once", 64'(out_valid), 0);
    cyc(0, '0, '0, 1, 1);
    cyc(1, rnd() | 48'h1, 4'b0000, 1, 0);
    #1 chk("zero_s0", 64'(out_zero), 1);
    cyc(1, '0, 4'b1111, 1, 0);
    #1 chk("zero_d0", 64'(out_zero), 1);
    cyc(0, '0, '0, 1, 0);
`ifdef GATED_MUX_ZERO_CNT_EN
    #1 chk("zero_cnt2", 64'(zero_cnt), 2);
`endif
    a = rnd(); b = rnd(); c = rnd();
    cyc(1, a, 4'hF, 0, 0);
    cyc(1, b, 4'hF, 0, 0);
    #1 chk("bp_ready", 64'(in_ready), 0);
    chk("bp_main", 64'(out), 64'(a));
    cyc(1, c, 4'hF, 0, 0);
    cyc(1, c, 4'hF, 1, 0);
    #1 chk("bp_b", 64'(out), 64'(b));
    cyc(1, c, 4'hF, 1, 0);
    #1 chk("bp_c", 64'(out), 64'(c));
    cyc(0, '0, '0, 1, 0);
    #1 chk("bp_empty", 64'(out_valid), 0);
    for (int k = 0; k < 40; k++) cyc(1, rnd(), C'($urandom()), k[0], 0);
    cyc(0, '0, '0, 1, 0);
    cyc(1, rnd(), 4'hF, 0, 0);
    cyc(1, rnd(), 4'hF, 0, 0);
    cyc(1, rnd(), 4'hF, 0, 1);
    #1 chk("flush_valid", 64'(out_valid), 0);
    chk("flush_ready", 64'(in_ready), 1);
`ifdef GATED_MUX_ZERO_CNT_EN
    chk("flush_cnt", 64'(zero_cnt), 0);
`endif
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? '0 : rnd(), C'($urandom()),
          $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    cyc(1, rnd(), 4'hF, 0, 0);
    cyc(1, rnd(), 4'hF, 0, 0);
    do_reset();
    for (int k = 0; k < 30; k++) cyc(1, rnd(), C'($urandom()), $urandom_range(0, 1) == 1, 0);
`ifdef GATED_MUX_ZERO_CNT_EN
    cyc(0, '0, '0, 1, 1);
    repeat (65540) cyc(1, '0, 4'hF, 1, 0);
    #1 chk("zero_sat", 64'(zero_cnt), 64'hFFFF);
`endif
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gated_mux_pipe.md
Name: gated_mux_pipe

Overview:
- Parametrised, pipelined successor to the single-channel 12-bit zero-gate mux used in the multiplier datapath.
- Gates CHANNELS operand lanes of WIDTH bits each: every lane either passes its input or is forced to zero, under its own select bit.
- Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so the block sits between multiplier pipeline stages without combinational ready paths.

Parameters:
- WIDTH, 12, bits per lane.
- CHANNELS, 4, number of independently gated lanes (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear; drops all buffered entries.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept; registered, never combinationally derived from out_ready.
- in  input  WIDTH*CHANNELS  lane i at bits [i*WIDTH +: WIDTH].
- s  input  CHANNELS  per-lane gate: 1 passes lane, 0 forces lane to zero.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out  output  WIDTH*CHANNELS  gated lanes, same packing as in.
- out_zero  output  1  all lanes of the current out entry are zero; qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out=0, out_zero=0, in_ready=1, both buffer entries empty.
  - Reset asserted mid-transfer discards all entries.
- Accept and gating:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Lane i is captured as s[i] ? in lane i : 0. Gating is applied at capture; s is not held afterward.
  - out_zero is captured as the NOR of all gated lanes. It is also 1 when s is nonzero but the passed data is zero.
- Latency: one cycle. Data accepted at edge N is visible on out with out_valid=1 after edge N when the buffer was empty.
- Buffer: main register drives out; skid register holds one extra entry.
  - Output transfer occurs when out_valid && out_ready.
  - Empty + accept -> main.
  - Main full, transfer + accept -> main replaced by new data.
  - Main full, no transfer + accept -> skid.
  - Both full + transfer -> skid moves to main, skid empties.
  - in_ready next = !(skid full after this edge). Accepting into skid drops in_ready on the following cycle.
  - No accept occurs while in_ready=0, even if in_valid=1.
- Ordering: strict FIFO. No entry is dropped or duplicated except on flush or reset.
- flush:
  - At the edge, both entries empty, out_valid=0, in_ready=1.
  - An accept in the same cycle as flush is discarded; flush wins.
  - out is not required to clear on flush; out_zero is don't-care while out_valid=0.
- Stability: while out_valid && !out_ready, out and out_zero hold constant.
- CHANNELS=1, WIDTH=12 with the buffer always drained reproduces single-lane gating plus one cycle of latency.

Optional Feature:
- Macro GATED_MUX_ZERO_CNT_EN.
- When defined:
  - Adds output zero_cnt [15:0].
  - zero_cnt increments on each output transfer whose out_zero=1 and saturates at 16'hFFFF.
  - zero_cnt is reset to 0 by rst_n and by flush.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, WIDTH=12, CHANNELS=4 -> out_valid=0, in_ready=1, out=0. Deassert reset mid-stream -> no spurious out_valid.
- Single beat, in lanes = 12'hABC, 12'h123, 12'hFFF, 12'h001, s=4'b0101, out_ready=1 -> next cycle out lanes = ABC, 000, FFF, 000; out_zero=0; out_valid for exactly one cycle.
- s=4'b0000 with any data, then s=4'b1111 with all-zero data -> out_zero=1 both times. With the macro defined, zero_cnt=2.
- Backpressure: out_ready=0, present three beats A, B, C -> A in main, B in skid, in_ready=0 and C not accepted. Release out_ready -> out shows A, B, C in order with no loss.
- Streaming with out_ready toggling each cycle and in_valid=1 continuously -> output sequence equals input sequence; in_ready never depends combinationally on out_ready.
- flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed beat absent. With the macro defined, zero_cnt=0. Separately, force 65536 all-zero transfers -> zero_cnt saturates at 16'hFFFF.
